// File: rtl/ysyx_23060025_lsu_stage_pkg.sv
// Shared encodings for the LSU stage: load/store kinds, AXI responses,
// FSM states and bus widths used between pipeline stages.
package ysyx_23060025_lsu_stage_pkg;

    localparam logic [2:0] LOAD_NONE = 3'd0;
    localparam logic [2:0] LOAD_LB   = 3'd1;
    localparam logic [2:0] LOAD_LH   = 3'd2;
    localparam logic [2:0] LOAD_LW   = 3'd3;
    localparam logic [2:0] LOAD_LBU  = 3'd4;
    localparam logic [2:0] LOAD_LHU  = 3'd5;

    localparam logic [1:0] STORE_NONE = 2'd0;
    localparam logic [1:0] STORE_SB   = 2'd1;
    localparam logic [1:0] STORE_SH   = 2'd2;
    localparam logic [1:0] STORE_SW   = 2'd3;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam int MS_TO_DS_FORWARD_BUS = 39;
    localparam int CSR_BUS              = 47;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AR   = 3'd1,
        ST_R    = 3'd2,
        ST_WR   = 3'd3,
        ST_B    = 3'd4,
        ST_DONE = 3'd5
    } lsu_state_e;

endpackage

// File: rtl/ysyx_23060025_lsu_align.sv
// Combinational byte-lane steering: store strobes/data replication and
// load data extraction with sign or zero extension.
module ysyx_23060025_lsu_align
    import ysyx_23060025_lsu_stage_pkg::*;
#(
    parameter int DATA_LEN = 32
) (
    input  logic [1:0]          addr_lo_i,
    input  logic [1:0]          store_type_i,
    input  logic [2:0]          load_type_i,
    input  logic [DATA_LEN-1:0] store_src_i,
    input  logic [DATA_LEN-1:0] rdata_i,
    output logic [3:0]          wstrb_o,
    output logic [DATA_LEN-1:0] wdata_o,
    output logic [DATA_LEN-1:0] load_data_o
);

    function automatic logic [DATA_LEN-1:0] sext8(input logic signed [7:0] v);
        logic signed [DATA_LEN-1:0] w;
        w = DATA_LEN'(v);
        return w;
    endfunction

    function automatic logic [DATA_LEN-1:0] sext16(input logic signed [15:0] v);
        logic signed [DATA_LEN-1:0] w;
        w = DATA_LEN'(v);
        return w;
    endfunction

    logic                is_half;
    logic [1:0]          load_off;
    logic [DATA_LEN-1:0] shifted;

    always_comb begin
        wstrb_o = 4'h0;
        wdata_o = store_src_i;
        unique case (store_type_i)
            STORE_SB: begin
                wstrb_o = 4'b0001 << addr_lo_i;
                wdata_o = {4{store_src_i[7:0]}};
            end
            STORE_SH: begin
                wstrb_o = 4'b0011 << {addr_lo_i[1], 1'b0};
                wdata_o = {2{store_src_i[15:0]}};
            end
            STORE_SW: wstrb_o = 4'hF;
            default:  wstrb_o = 4'h0;
        endcase
    end

    // Halfword loads ignore addr[0] so the lane never straddles the word.
    always_comb begin
        is_half  = (load_type_i == LOAD_LH) || (load_type_i == LOAD_LHU);
        load_off = is_half ? {addr_lo_i[1], 1'b0} : addr_lo_i;
        shifted  = rdata_i >> {load_off, 3'b000};
        unique case (load_type_i)
            LOAD_LB:  load_data_o = sext8(shifted[7:0]);
            LOAD_LH:  load_data_o = sext16(shifted[15:0]);
            LOAD_LBU: load_data_o = DATA_LEN'(shifted[7:0]);
            LOAD_LHU: load_data_o = DATA_LEN'(shifted[15:0]);
            default:  load_data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/ysyx_23060025_lsu_stage.sv
// Memory-access pipeline stage: one AXI4-Lite-style transaction per load or
// store, then hands the result to writeback and forwards it to decode.
module ysyx_23060025_lsu_stage
    import ysyx_23060025_lsu_stage_pkg::*;
#(
    parameter int DATA_LEN = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 es_to_ms_valid_i,
    output logic                 ms_allowin_o,
    input  logic [2:0]           load_type_i,
    input  logic [1:0]           store_type_i,
    input  logic [DATA_LEN-1:0]  mem_wdata_i,
    input  logic [DATA_LEN-1:0]  alu_result_i,
    input  logic                 wd_i,
    input  logic [4:0]           wreg_i,
    input  logic [DATA_LEN-1:0]  pc_i,
    input  logic [CSR_BUS-1:0]   csr_bus_i,
    input  logic                 ebreak_flag_i,
    output logic                 ms_to_ws_valid_o,
    input  logic                 ws_allowin_i,
    output logic                 wd_o,
    output logic [4:0]           wreg_o,
    output logic [DATA_LEN-1:0]  pc_o,
    output logic [CSR_BUS-1:0]   csr_bus_o,
    output logic                 ebreak_flag_o,
    output logic [DATA_LEN-1:0]  ms_result_o,
    output logic                 bus_err_o,
    output logic [MS_TO_DS_FORWARD_BUS-1:0] ms_to_ds_forward_bus_o,
    output logic [DATA_LEN-1:0]  araddr_o,
    output logic                 arvalid_o,
    input  logic                 arready_i,
    input  logic [DATA_LEN-1:0]  rdata_i,
    input  logic [1:0]           rresp_i,
    input  logic                 rvalid_i,
    output logic                 rready_o,
    output logic [DATA_LEN-1:0]  awaddr_o,
    output logic                 awvalid_o,
    input  logic                 awready_i,
    output logic [DATA_LEN-1:0]  wdata_o,
    output logic [3:0]           wstrb_o,
    output logic                 wvalid_o,
    input  logic                 wready_i,
    input  logic [1:0]           bresp_i,
    input  logic                 bvalid_i,
    output logic                 bready_o
);

    lsu_state_e          state_q, state_d;
    logic                ms_valid_q, ms_valid_d;
    logic [2:0]          load_type_q, load_type_d;
    logic [1:0]          store_type_q, store_type_d;
    logic [DATA_LEN-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_LEN-1:0] addr_q, addr_d;
    logic [DATA_LEN-1:0] pc_q, pc_d;
    logic [DATA_LEN-1:0] load_data_q, load_data_d;
    logic                wd_q, wd_d;
    logic [4:0]          wreg_q, wreg_d;
    logic [CSR_BUS-1:0]  csr_bus_q, csr_bus_d;
    logic                ebreak_q, ebreak_d;
    logic                arvalid_q, arvalid_d;
    logic                rready_q, rready_d;
    logic                awvalid_q, awvalid_d;
    logic                wvalid_q, wvalid_d;
    logic                bready_q, bready_d;
    logic                aw_done_q, aw_done_d;
    logic                w_done_q, w_done_d;
    logic                bus_err_q, bus_err_d;

    logic                is_load, is_store, ms_ready_go, capture;
    logic                in_load, in_store, aw_now, w_now;
    logic [DATA_LEN-1:0] align_load;

    ysyx_23060025_lsu_align #(.DATA_LEN(DATA_LEN)) u_align (
        .addr_lo_i    (addr_q[1:0]),
        .store_type_i (store_type_q),
        .load_type_i  (load_type_q),
        .store_src_i  (mem_wdata_q),
        .rdata_i      (rdata_i),
        .wstrb_o      (wstrb_o),
        .wdata_o      (wdata_o),
        .load_data_o  (align_load)
    );

    assign is_load      = (load_type_q != LOAD_NONE);
    assign is_store     = (store_type_q != STORE_NONE);
    assign ms_ready_go  = (is_load || is_store) ? (state_q == ST_DONE) : 1'b1;
    assign ms_allowin_o = !ms_valid_q || (ms_ready_go && ws_allowin_i);
    assign capture      = es_to_ms_valid_i && ms_allowin_o;
    assign in_load      = (load_type_i != LOAD_NONE);
    assign in_store     = (store_type_i != STORE_NONE);
    assign aw_now       = aw_done_q || (awvalid_q && awready_i);
    assign w_now        = w_done_q || (wvalid_q && wready_i);

    always_comb begin
        state_d      = state_q;
        ms_valid_d   = ms_valid_q;
        load_type_d  = load_type_q;
        store_type_d = store_type_q;
        mem_wdata_d  = mem_wdata_q;
        addr_d       = addr_q;
        pc_d         = pc_q;
        load_data_d  = load_data_q;
        wd_d         = wd_q;
        wreg_d       = wreg_q;
        csr_bus_d    = csr_bus_q;
        ebreak_d     = ebreak_q;
        arvalid_d    = arvalid_q;
        rready_d     = rready_q;
        awvalid_d    = awvalid_q;
        wvalid_d     = wvalid_q;
        bready_d     = bready_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        bus_err_d    = 1'b0;

        if (ms_allowin_o) ms_valid_d = es_to_ms_valid_i;
        if (capture) begin
            load_type_d  = load_type_i;
            store_type_d = store_type_i;
            mem_wdata_d  = mem_wdata_i;
            addr_d       = alu_result_i;
            pc_d         = pc_i;
            wd_d         = wd_i;
            wreg_d       = wreg_i;
            csr_bus_d    = csr_bus_i;
            ebreak_d     = ebreak_flag_i;
        end

        unique case (state_q)
            ST_AR: if (arready_i) begin
                arvalid_d = 1'b0;
                rready_d  = 1'b1;
                state_d   = ST_R;
            end
            ST_R: if (rvalid_i) begin
                load_data_d = align_load;
                rready_d    = 1'b0;
                bus_err_d   = (rresp_i != AXI_RESP_OKAY);
                state_d     = ST_DONE;
            end
            ST_WR: begin
                awvalid_d = awvalid_q && !awready_i;
                wvalid_d  = wvalid_q && !wready_i;
                if (aw_now && w_now) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    bready_d  = 1'b1;
                    state_d   = ST_B;
                end else begin
                    aw_done_d = aw_now;
                    w_done_d  = w_now;
                end
            end
            ST_B: if (bvalid_i) begin
                bready_d  = 1'b0;
                bus_err_d = (bresp_i != AXI_RESP_OKAY);
                state_d   = ST_DONE;
            end
            ST_DONE: if (ws_allowin_i) state_d = ST_IDLE;
            default: ;
        endcase

        // A newly captured memory op launches immediately, even straight out of DONE.
        if (capture && in_load) begin
            arvalid_d = 1'b1;
            state_d   = ST_AR;
        end else if (capture && in_store) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = ST_WR;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            ms_valid_q   <= 1'b0;
            load_type_q  <= LOAD_NONE;
            store_type_q <= STORE_NONE;
            mem_wdata_q  <= '0;
            addr_q       <= '0;
            pc_q         <= '0;
            load_data_q  <= '0;
            wd_q         <= 1'b0;
            wreg_q       <= '0;
            csr_bus_q    <= '0;
            ebreak_q     <= 1'b0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ms_valid_q   <= ms_valid_d;
            load_type_q  <= load_type_d;
            store_type_q <= store_type_d;
            mem_wdata_q  <= mem_wdata_d;
            addr_q       <= addr_d;
            pc_q         <= pc_d;
            load_data_q  <= load_data_d;
            wd_q         <= wd_d;
            wreg_q       <= wreg_d;
            csr_bus_q    <= csr_bus_d;
            ebreak_q     <= ebreak_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            awvalid_q    <= awvalid_d;
            wvalid_q     <= wvalid_d;
            bready_q     <= bready_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
            bus_err_q    <= bus_err_d;
        end
    end

    assign ms_to_ws_valid_o = ms_valid_q && ms_ready_go;
    assign ms_result_o      = is_load ? load_data_q : addr_q;
    assign wd_o             = wd_q;
    assign wreg_o           = wreg_q;
    assign pc_o             = pc_q;
    assign csr_bus_o        = csr_bus_q;
    assign ebreak_flag_o    = ebreak_q;
    assign bus_err_o        = bus_err_q;
    assign araddr_o         = {addr_q[DATA_LEN-1:2], 2'b00};
    assign awaddr_o         = {addr_q[DATA_LEN-1:2], 2'b00};
    assign arvalid_o        = arvalid_q;
    assign rready_o         = rready_q;
    assign awvalid_o        = awvalid_q;
    assign wvalid_o         = wvalid_q;
    assign bready_o         = bready_q;

    // A load still in flight cannot forward yet, so decode must stall on it.
    assign ms_to_ds_forward_bus_o = {
        ms_valid_q && is_load && (state_q != ST_DONE),
        ms_valid_q && wd_q && (wreg_q != 5'd0),
        wreg_q,
        ms_result_o
    };

endmodule

// File: tb/tb_ysyx_23060025_lsu_stage.sv
// Directed bench for the LSU stage: scoreboard of committed results plus
// step-by-step checks of the AXI channel handshakes.
module tb_ysyx_23060025_lsu_stage;
    import ysyx_23060025_lsu_stage_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        es_to_ms_valid_i, ms_allowin_o;
    logic [2:0]  load_type_i;
    logic [1:0]  store_type_i;
    logic [31:0] mem_wdata_i, alu_result_i, pc_i;
    logic        wd_i, ebreak_flag_i;
    logic [4:0]  wreg_i;
    logic [46:0] csr_bus_i;
    logic        ms_to_ws_valid_o, ws_allowin_i;
    logic        wd_o, ebreak_flag_o, bus_err_o;
    logic [4:0]  wreg_o;
    logic [31:0] pc_o, ms_result_o;
    logic [46:0] csr_bus_o;
    logic [38:0] fwd;
    logic [31:0] araddr_o, rdata_i, awaddr_o, wdata_o;
    logic        arvalid_o, arready_i, rvalid_i, rready_o;
    logic [1:0]  rresp_i, bresp_i;
    logic        awvalid_o, awready_i, wvalid_o, wready_i, bvalid_i, bready_o;
    logic [3:0]  wstrb_o;

    always #5 clock = ~clock;

    ysyx_23060025_lsu_stage dut (
        .clock(clock), .reset(reset),
        .es_to_ms_valid_i(es_to_ms_valid_i), .ms_allowin_o(ms_allowin_o),
        .load_type_i(load_type_i), .store_type_i(store_type_i),
        .mem_wdata_i(mem_wdata_i), .alu_result_i(alu_result_i),
        .wd_i(wd_i), .wreg_i(wreg_i), .pc_i(pc_i), .csr_bus_i(csr_bus_i),
        .ebreak_flag_i(ebreak_flag_i),
        .ms_to_ws_valid_o(ms_to_ws_valid_o), .ws_allowin_i(ws_allowin_i),
        .wd_o(wd_o), .wreg_o(wreg_o), .pc_o(pc_o), .csr_bus_o(csr_bus_o),
        .ebreak_flag_o(ebreak_flag_o), .ms_result_o(ms_result_o),
        .bus_err_o(bus_err_o), .ms_to_ds_forward_bus_o(fwd),
        .araddr_o(araddr_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
        .rdata_i(rdata_i), .rresp_i(rresp_i), .rvalid_i(rvalid_i), .rready_o(rready_o),
        .awaddr_o(awaddr_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
        .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wvalid_o(wvalid_o), .wready_i(wready_i),
        .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o)
    );

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] pc;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] res, input logic [31:0] pc);
        exp_t e;
        e.res = res;
        e.pc  = pc;
        sb.push_back(e);
    endtask

    task automatic issue(input logic [2:0] lt, input logic [1:0] st, input logic [31:0] rs2,
                         input logic [31:0] addr, input logic wd, input logic [4:0] wr,
                         input logic [31:0] pc, input logic [46:0] csr, input logic eb);
        int n;
        es_to_ms_valid_i = 1'b1;
        load_type_i = lt;  store_type_i = st;  mem_wdata_i = rs2;  alu_result_i = addr;
        wd_i = wd;  wreg_i = wr;  pc_i = pc;  csr_bus_i = csr;  ebreak_flag_i = eb;
        n = 0;
        @(negedge clock);
        while (!ms_allowin_o && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (!ms_allowin_o) chk("issue_timeout", ms_allowin_o, 1);
        @(posedge clock);
        #1;
        es_to_ms_valid_i = 1'b0;
    endtask

    task automatic do_read(input int ar_delay, input int r_delay,
                           input logic [31:0] d, input logic [1:0] resp);
        for (int i = 0; i < ar_delay; i++) begin
            chk("arvalid_hold", arvalid_o, 1);
            step();
        end
        arready_i = 1'b1;
        step();
        arready_i = 1'b0;
        chk("rready_up", rready_o, 1);
        chk("arvalid_drop", arvalid_o, 0);
        chk("stall_in_r", fwd[38], 1);
        for (int i = 0; i < r_delay; i++) step();
        rvalid_i = 1'b1;  rdata_i = d;  rresp_i = resp;
        step();
        rvalid_i = 1'b0;
        chk("rready_drop", rready_o, 0);
    endtask

    // Commit monitor: every result WB accepts must match the oldest expectation.
    always @(negedge clock) begin
        exp_t e;
        if (reset && ms_to_ws_valid_o && ws_allowin_i) begin
            if (sb.size() == 0) begin
                n_assert++;
                n_fail++;
                $error("FAIL unexpected_commit: observed pc 0x%0h result 0x%0h, expected no commit",
                       pc_o, ms_result_o);
            end else begin
                e = sb.pop_front();
                chk("commit_result", ms_result_o, e.res);
                chk("commit_pc", pc_o, e.pc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        es_to_ms_valid_i = 0; load_type_i = 0; store_type_i = 0; mem_wdata_i = 0;
        alu_result_i = 0; wd_i = 0; wreg_i = 0; pc_i = 0; csr_bus_i = 0; ebreak_flag_i = 0;
        ws_allowin_i = 1; arready_i = 0; rdata_i = 0; rresp_i = 0; rvalid_i = 0;
        awready_i = 0; wready_i = 0; bresp_i = 0; bvalid_i = 0;
        repeat (3) step();

        chk("rst_to_ws_valid", ms_to_ws_valid_o, 0);
        chk("rst_allowin", ms_allowin_o, 1);
        chk("rst_axi_valids", {arvalid_o, rready_o, awvalid_o, wvalid_o, bready_o}, 0);
        chk("rst_result", ms_result_o, 0);
        chk("rst_fwd", fwd, 0);
        chk("rst_pc", pc_o, 0);
        chk("rst_bus_err", bus_err_o, 0);
        reset = 1'b1;
        step();

        // Non-memory op passes through in zero cycles.
        push_exp(32'h0000_1234, 32'h8000_0100);
        issue(LOAD_NONE, STORE_NONE, 32'h0, 32'h0000_1234, 1'b1, 5'd5,
              32'h8000_0100, 47'h1234_5678_9ABC, 1'b1);
        chk("alu_to_ws_valid", ms_to_ws_valid_o, 1);
        chk("alu_no_axi", {arvalid_o, awvalid_o, wvalid_o}, 0);
        chk("alu_fwd", fwd, {1'b0, 1'b1, 5'd5, 32'h0000_1234});
        chk("alu_csr", csr_bus_o, 47'h1234_5678_9ABC);
        chk("alu_ebreak_wreg", {ebreak_flag_o, wd_o, wreg_o}, {1'b1, 1'b1, 5'd5});
        step();
        chk("alu_drained", ms_to_ws_valid_o, 0);

        // LB with delayed arready/rvalid, sign-extended byte 0x80.
        push_exp(32'hFFFF_FF80, 32'h8000_0104);
        issue(LOAD_LB, STORE_NONE, 32'h0, 32'h8000_0003, 1'b1, 5'd7, 32'h8000_0104, 47'h0, 1'b0);
        chk("lb_araddr", araddr_o, 32'h8000_0000);
        chk("lb_arvalid", arvalid_o, 1);
        chk("lb_stall", fwd[38], 1);
        chk("lb_not_ready", ms_to_ws_valid_o, 0);
        do_read(2, 2, 32'h80FF_0000, AXI_RESP_OKAY);
        chk("lb_done_valid", ms_to_ws_valid_o, 1);
        chk("lb_stall_clear", fwd[38], 0);
        chk("lb_fwd_en", fwd[37], 1);
        chk("lb_no_bus_err", bus_err_o, 0);
        step();

        push_exp(32'h0000_BEEF, 32'h8000_0108);
        issue(LOAD_LHU, STORE_NONE, 32'h0, 32'h8000_0002, 1'b1, 5'd8, 32'h8000_0108, 47'h0, 1'b0);
        do_read(0, 0, 32'hBEEF_1234, AXI_RESP_OKAY);
        step();

        push_exp(32'hBEEF_1234, 32'h8000_010C);
        issue(LOAD_LW, STORE_NONE, 32'h0, 32'h8000_0000, 1'b1, 5'd9, 32'h8000_010C, 47'h0, 1'b0);
        do_read(1, 0, 32'hBEEF_1234, AXI_RESP_OKAY);
        step();

        // SH: W handshake before AW, then an error response.
        push_exp(32'h8000_0006, 32'h8000_0110);
        issue(LOAD_NONE, STORE_SH, 32'h0000_ABCD, 32'h8000_0006, 1'b0, 5'd0,
              32'h8000_0110, 47'h0, 1'b0);
        chk("sh_awaddr", awaddr_o, 32'h8000_0004);
        chk("sh_wstrb", wstrb_o, 4'b1100);
        chk("sh_wdata", wdata_o, 32'hABCD_ABCD);
        chk("sh_valids", {awvalid_o, wvalid_o}, 2'b11);
        wready_i = 1'b1;
        step();
        wready_i = 1'b0;
        chk("sh_w_first", {awvalid_o, wvalid_o, bready_o}, 3'b100);
        awready_i = 1'b1;
        step();
        awready_i = 1'b0;
        chk("sh_aw_second", {awvalid_o, wvalid_o, bready_o}, 3'b001);
        bvalid_i = 1'b1;  bresp_i = AXI_RESP_SLVERR;
        step();
        bvalid_i = 1'b0;  bresp_i = AXI_RESP_OKAY;
        chk("sh_bus_err", bus_err_o, 1);
        chk("sh_bready_drop", bready_o, 0);
        chk("sh_done_valid", ms_to_ws_valid_o, 1);
        step();
        chk("sh_bus_err_pulse", bus_err_o, 0);

        // LW held at DONE by WB back-pressure while an SW waits upstream.
        ws_allowin_i = 1'b0;
        push_exp(32'h1122_3344, 32'h8000_0114);
        issue(LOAD_LW, STORE_NONE, 32'h0, 32'h8000_0010, 1'b1, 5'd10, 32'h8000_0114, 47'h0, 1'b0);
        do_read(0, 1, 32'h1122_3344, AXI_RESP_OKAY);
        es_to_ms_valid_i = 1'b1;  load_type_i = LOAD_NONE;  store_type_i = STORE_SW;
        mem_wdata_i = 32'hCAFE_F00D;  alu_result_i = 32'h8000_0020;  wd_i = 1'b0;
        wreg_i = 5'd0;  pc_i = 32'h8000_0118;
        for (int i = 0; i < 3; i++) begin
            chk("hold_allowin", ms_allowin_o, 0);
            chk("hold_valid", ms_to_ws_valid_o, 1);
            chk("hold_result", ms_result_o, 32'h1122_3344);
            chk("hold_no_aw", awvalid_o, 0);
            step();
        end
        ws_allowin_i = 1'b1;
        push_exp(32'h8000_0020, 32'h8000_0118);
        step();
        es_to_ms_valid_i = 1'b0;
        chk("sw_valids", {awvalid_o, wvalid_o}, 2'b11);
        chk("sw_wstrb", wstrb_o, 4'hF);
        chk("sw_wdata", wdata_o, 32'hCAFE_F00D);
        chk("sw_awaddr", awaddr_o, 32'h8000_0020);
        awready_i = 1'b1;  wready_i = 1'b1;
        step();
        awready_i = 1'b0;  wready_i = 1'b0;
        chk("sw_same_cycle", {awvalid_o, wvalid_o, bready_o}, 3'b001);
        bvalid_i = 1'b1;
        step();
        bvalid_i = 1'b0;
        chk("sw_no_bus_err", bus_err_o, 0);
        step();

        // Reset while waiting for read data aborts the load.
        issue(LOAD_LW, STORE_NONE, 32'h0, 32'h8000_0030, 1'b1, 5'd11, 32'h8000_011C, 47'h0, 1'b0);
        arready_i = 1'b1;
        step();
        arready_i = 1'b0;
        chk("pre_rst_rready", rready_o, 1);
        reset = 1'b0;
        step();
        chk("rst_mid_rready", rready_o, 0);
        chk("rst_mid_arvalid", arvalid_o, 0);
        chk("rst_mid_valid", ms_to_ws_valid_o, 0);
        chk("rst_mid_allowin", ms_allowin_o, 1);
        chk("rst_mid_stall", fwd[38], 0);
        reset = 1'b1;
        repeat (2) step();

        chk("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_23060025_lsu_stage.md
Name: ysyx_23060025_lsu_stage

Overview:
- Memory-access stage directly downstream of the execute stage.
- Accepts one instruction per valid/allowin handshake from EX.
- For loads/stores, runs a single AXI4-Lite-style transaction (32-bit address and data, one outstanding), then aligns and extends load data.
- Hands the result to writeback and drives the MS->DS forward/stall bus.

Parameters:
- DATA_LEN, 32, datapath and address width.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low reset (asserted when 0)
- es_to_ms_valid_i  in  1  EX has a valid instruction
- ms_allowin_o  out  1  stage can accept this cycle
- load_type_i  in  3  LOAD_NONE/LB/LH/LW/LBU/LHU
- store_type_i  in  2  STORE_NONE/SB/SH/SW
- mem_wdata_i  in  32  store source (rs2)
- alu_result_i  in  32  effective address, or ALU result for non-memory ops
- wd_i  in  1  writes GPR
- wreg_i  in  5  destination register
- pc_i  in  32  instruction PC
- csr_bus_i  in  47  {csr_type[2:0], csr_waddr[11:0], csr_wdata[31:0]} passthrough
- ebreak_flag_i  in  1  passthrough
- ms_to_ws_valid_o  out  1  result valid for WB
- ws_allowin_i  in  1  WB can accept
- wd_o, wreg_o, pc_o, csr_bus_o, ebreak_flag_o  out  1/5/32/47/1  registered copies
- ms_result_o  out  32  load data, or the registered alu_result
- bus_err_o  out  1  one-cycle pulse when rresp/bresp != 0
- ms_to_ds_forward_bus_o  out  39  {dep_need_stall, forward_enable, wreg, ms_result}
- araddr_o/arvalid_o/arready_i  32/1/1  read address channel
- rdata_i/rresp_i/rvalid_i/rready_o  32/2/1/1  read data channel
- awaddr_o/awvalid_o/awready_i  32/1/1  write address channel
- wdata_o/wstrb_o/wvalid_o/wready_i  32/4/1/1  write data channel
- bresp_i/bvalid_i/bready_o  2/1/1  write response channel

Behaviour:
- Reset: ms_valid=0, FSM=IDLE, all valid/ready outputs 0, all registered data outputs 0, bus_err_o=0.
- Reset mid-transaction aborts the transaction. The slave is reset in the same cycle.
- Pipeline control:
  - ms_allowin_o = !ms_valid || (ms_ready_go && ws_allowin_i).
  - On ms_allowin_o: ms_valid <= es_to_ms_valid_i.
  - Input fields are captured when es_to_ms_valid_i && ms_allowin_o.
  - ms_to_ws_valid_o = ms_valid && ms_ready_go.
  - ms_ready_go = 1 for non-memory ops (zero-cycle stage). For memory ops, ms_ready_go = (FSM==DONE).
- FSM states: IDLE, AR, R, WR, B, DONE.
- IDLE:
  - Captured valid load: assert arvalid, go to AR.
  - Captured valid store: assert awvalid and wvalid, go to WR.
- AR: arvalid held with stable araddr until arready. Then drop arvalid, raise rready, go to R.
- R: on rvalid, latch the extended data, drop rready, go to DONE.
- WR:
  - aw and w handshakes complete independently, in either order or the same cycle; each valid drops after its own handshake.
  - When both are done, raise bready and go to B.
- B: on bvalid, drop bready, go to DONE.
- DONE: when ws_allowin_i, leave DONE. Go to IDLE, or start the next transaction directly if a new memory op is captured in the same cycle.
- Address and strobes:
  - araddr = awaddr = captured addr with [1:0] cleared.
  - a = addr[1:0].
  - SB: wstrb = 4'b0001<<a, wdata = {4{byte}}.
  - SH: wstrb = 4'b0011<<{a[1],1'b0}, wdata = {2{half}}; addr[0] is ignored.
  - SW: wstrb = 4'hF.
- Load extract: shifted = rdata >> (8*a), with a[0] forced to 0 for halfword loads. LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
- Bus error: resp != 0 pulses bus_err_o for one cycle. The data is still committed (trap handling belongs to WB).
- Forwarding:
  - forward_enable = ms_valid && wd && wreg != 0.
  - dep_need_stall = ms_valid && load && FSM != DONE.

Decomposition:
- Shared define file holds:
  - LOAD_* and STORE_* encodings (NONE=0; LB=1, LH=2, LW=3, LBU=4, LHU=5; SB=1, SH=2, SW=3).
  - AXI resp constants.
  - FSM state encodings.
  - MS_TO_DS_FORWARD_BUS = 39, CSR_BUS = 47.
- One sub-module: ysyx_23060025_lsu_align (combinational wstrb/wdata generation and load extract/extend).

Test Plan:
- Non-memory op (alu_result=0x1234, wreg=5, ws_allowin=1) -> ms_to_ws_valid_o=1 the cycle after capture; ms_result_o=0x1234; no AXI valid raised.
- LB at addr 0x8000_0003, rdata=0x80FF_0000, arready and rvalid each delayed 2 cycles -> araddr=0x8000_0000; result 0xFFFF_FF80; dep_need_stall=1 until DONE.
- LHU at 0x8000_0002, rdata=0xBEEF_1234 -> 0x0000_BEEF. LW at the same word -> 0xBEEF_1234.
- SH rs2=0x0000_ABCD at 0x8000_0006 with wready one cycle before awready -> wstrb=4'b1100, wdata=0xABCD_ABCD, each valid drops after its own handshake; bvalid with bresp=2 -> bus_err_o pulses 1 cycle.
- Back-to-back LW/SW with ws_allowin held 0 for 3 cycles at DONE -> result held stable, ms_allowin_o=0, second op not captured until release.
- reset driven 0 while in R -> next cycle FSM=IDLE, rready=0, ms_valid=0.
